// File: rtl/dbus_sram_rsp.sv
// Data-bus slave responder: one outstanding request, byte-lane RAM writes,
// right-aligned zero-padded reads, response pulse after WAIT_CYCLES wait states.
module dbus_sram_rsp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dbus_req,
  input  logic        i_dbus_we,
  input  logic [3:0]  i_dbus_sel,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  output logic [31:0] o_dbus_rdata,
  output logic        o_dbus_rsp,
  output logic        o_dbus_err,
  output logic        o_busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  LP_WAIT  = 4'(WAIT_CYCLES);
  localparam logic [33:0] LP_BYTES = 34'(DEPTH) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic          r_we, r_err;
  logic [3:0]    r_sel;
  logic [31:0]   r_addr, r_wdata;
  logic [31:0]   r_rdata;
  logic          r_rsp, r_rsp_err, r_busy;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_off_in, w_cur_off, w_cur_addr, w_cur_wdata, w_word, w_wd, w_rfmt;
  logic [3:0]    w_cur_sel, w_be;
  logic [1:0]    w_lane;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_byte;
  logic          w_sel_ok, w_err_in, w_idle, w_cur_we, w_cur_err;
  logic          w_enter_resp, w_commit;

  assign w_off_in = i_dbus_addr - BASE_ADDR;
  assign w_sel_ok = (i_dbus_sel == 4'b0001) || (i_dbus_sel == 4'b0011) ||
                    (i_dbus_sel == 4'b1111);
  assign w_err_in = ({2'b00, w_off_in} >= LP_BYTES) || !w_sel_ok ||
                    ((i_dbus_sel == 4'b0011) && i_dbus_addr[0]) ||
                    ((i_dbus_sel == 4'b1111) && (i_dbus_addr[1:0] != 2'b00));

  // With no wait states RESP is entered on the capture edge itself, so the
  // live inputs stand in for the holding registers while in IDLE.
  assign w_idle      = (r_state == S_IDLE);
  assign w_cur_we    = w_idle ? i_dbus_we    : r_we;
  assign w_cur_sel   = w_idle ? i_dbus_sel   : r_sel;
  assign w_cur_addr  = w_idle ? i_dbus_addr  : r_addr;
  assign w_cur_wdata = w_idle ? i_dbus_wdata : r_wdata;
  assign w_cur_err   = w_idle ? w_err_in     : r_err;

  assign w_cur_off = w_cur_addr - BASE_ADDR;
  assign w_idx     = AW'(w_cur_off >> 2);
  assign w_lane    = w_cur_addr[1:0];
  assign w_word    = r_mem[w_idx];
  assign w_byte    = 8'(w_word >> {w_lane, 3'b000});

  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_commit     = w_enter_resp && w_cur_we && !w_cur_err && !i_rst;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_dbus_req) begin
          w_cnt_next = LP_WAIT;
          w_next     = (LP_WAIT != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_be   = 4'b1111;
    w_wd   = w_cur_wdata;
    w_rfmt = w_word;
    case (w_cur_sel)
      4'b0001: begin
        w_be   = 4'b0001 << w_lane;
        w_wd   = {4{w_cur_wdata[7:0]}};
        w_rfmt = {24'b0, w_byte};
      end
      4'b0011: begin
        w_be   = 4'b0011 << w_lane;
        w_wd   = {2{w_cur_wdata[15:0]}};
        w_rfmt = {16'b0, (w_lane[1] ? w_word[31:16] : w_word[15:0])};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_sel     <= 4'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_err     <= 1'b0;
      r_rdata   <= 32'd0;
      r_rsp     <= 1'b0;
      r_rsp_err <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_rsp     <= w_enter_resp;
      r_rsp_err <= w_enter_resp && w_cur_err;
      r_rdata   <= (w_enter_resp && !w_cur_we && !w_cur_err) ? w_rfmt : 32'd0;
      r_busy    <= (w_next != S_IDLE);
      if (w_idle && i_dbus_req) begin
        r_we    <= i_dbus_we;
        r_sel   <= i_dbus_sel;
        r_addr  <= i_dbus_addr;
        r_wdata <= i_dbus_wdata;
        r_err   <= w_err_in;
      end
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
      end
    end
  end

  assign o_dbus_rdata = r_rdata;
  assign o_dbus_rsp   = r_rsp;
  assign o_dbus_err   = r_rsp_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_dbus_sram_rsp.sv
// Bench for dbus_sram_rsp: three instances (0, 3 and 2 wait states), directed
// steps plus random traffic checked against a byte-addressed memory model.
module tb_dbus_sram_rsp;

  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic        req   [3];
  logic [31:0] rdataO[3];
  logic        rspO  [3];
  logic        errO  [3];
  logic        busyO [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] lastRd;
  logic        lastErr;
  logic [7:0]  mdl [3][4096];

  always #5 i_clk = ~i_clk;

  dbus_sram_rsp #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_dbus_req(req[0]), .i_dbus_we(we),
    .i_dbus_sel(sel), .i_dbus_addr(addr), .i_dbus_wdata(wdata),
    .o_dbus_rdata(rdataO[0]), .o_dbus_rsp(rspO[0]), .o_dbus_err(errO[0]),
    .o_busy(busyO[0]));

  dbus_sram_rsp #(.DEPTH(1024), .WAIT_CYCLES(3), .BASE_ADDR(BASE1)) u1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_dbus_req(req[1]), .i_dbus_we(we),
    .i_dbus_sel(sel), .i_dbus_addr(addr), .i_dbus_wdata(wdata),
    .o_dbus_rdata(rdataO[1]), .o_dbus_rsp(rspO[1]), .o_dbus_err(errO[1]),
    .o_busy(busyO[1]));

  dbus_sram_rsp #(.DEPTH(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_dbus_req(req[2]), .i_dbus_we(we),
    .i_dbus_sel(sel), .i_dbus_addr(addr), .i_dbus_wdata(wdata),
    .o_dbus_rdata(rdataO[2]), .o_dbus_rsp(rspO[2]), .o_dbus_err(errO[2]),
    .o_busy(busyO[2]));

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  function automatic logic [31:0] baseOf(input int d);
    return (d == 1) ? BASE1 : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: little-endian byte memory, access of 1/2/4 bytes at offset.
  task automatic modelTxn(input int d, input logic mwe, input logic [3:0] msel,
                          input logic [31:0] maddr, input logic [31:0] mwd,
                          output logic [31:0] erd, output logic eer);
    logic [31:0] off;
    int n;
    off = maddr - baseOf(d);
    n = (msel == 4'b0001) ? 1 : (msel == 4'b0011) ? 2 : (msel == 4'b1111) ? 4 : 0;
    eer = (off >= 32'd4096) || (n == 0) || (n == 2 && maddr[0]) ||
          (n == 4 && maddr[1:0] != 2'b00);
    erd = 32'd0;
    if (!eer) begin
      for (int i = 0; i < n; i++) begin
        if (mwe) mdl[d][int'(off) + i] = mwd[8*i +: 8];
        else     erd[8*i +: 8] = mdl[d][int'(off) + i];
      end
    end
  endtask

  // One request: hold req through the RESP cycle, scramble the other
  // inputs after the accept edge, and report what came back.
  task automatic applyStimulus(input int d, input logic swe, input logic [3:0] ssel,
                               input logic [31:0] saddr, input logic [31:0] swd,
                               output logic [31:0] rd, output logic er,
                               output int lat, output logic busyAfter,
                               output logic rspAfter);
    logic got;
    @(negedge i_clk);
    we = swe; sel = ssel; addr = saddr; wdata = swd;
    req[d] = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
      if (rspO[d]) got = 1'b1;
      else if (lat == 1) begin
        we = 1'($urandom); sel = 4'($urandom); addr = $urandom; wdata = $urandom;
      end
    end
    rd = rdataO[d];
    er = errO[d];
    if (got) begin
      @(posedge i_clk);
      #1;
    end
    req[d]    = 1'b0;
    busyAfter = busyO[d];
    rspAfter  = rspO[d];
  endtask

  task automatic doTxn(input string tag, input int d, input logic swe,
                       input logic [3:0] ssel, input logic [31:0] saddr,
                       input logic [31:0] swd);
    logic [31:0] rd, erd;
    logic er, eer, busyAfter, rspAfter;
    int lat;
    applyStimulus(d, swe, ssel, saddr, swd, rd, er, lat, busyAfter, rspAfter);
    modelTxn(d, swe, ssel, saddr, swd, erd, eer);
    checkOutput({tag, ".rdata"}, rd, erd);
    checkOutput({tag, ".err"}, 32'(er), 32'(eer));
    checkOutput({tag, ".lat"}, 32'(lat), 32'(waitOf(d) + 1));
    checkOutput({tag, ".after"}, {30'd0, busyAfter, rspAfter}, 32'd0);
    lastRd  = rd;
    lastErr = er;
  endtask

  task automatic randomPhase(input int d, input int nOps);
    logic [31:0] base, a;
    logic [3:0]  s;
    int r;
    base = baseOf(d);
    for (int i = 0; i < 16; i++)
      doTxn($sformatf("init%0d_%0d", d, i), d, 1'b1, 4'b1111, base + 32'(4*i), $urandom);
    for (int i = 0; i < nOps; i++) begin
      case ($urandom_range(0, 3))
        0:       s = 4'b0001;
        1:       s = 4'b0011;
        2:       s = 4'b1111;
        default: s = 4'($urandom);
      endcase
      r = int'($urandom_range(0, 9));
      a = base + $urandom_range(0, 63);
      if (r == 0) a = base + 32'd4096 + $urandom_range(0, 63);
      if (r == 1) a = base - 32'd1 - $urandom_range(0, 15);
      doTxn($sformatf("rnd%0d_%0d", d, i), d, 1'($urandom), s, a, $urandom);
    end
  endtask

  initial begin
    int np, rspCount;
    int pulseAt[3];
    logic [31:0] pRd[3];
    logic [31:0] erd;
    logic eer;

    i_rst = 1'b1;
    we = 1'b0; sel = 4'd0; addr = 32'd0; wdata = 32'd0;
    for (int d = 0; d < 3; d++) req[d] = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset%0d.rdata", d), rdataO[d], 32'd0);
      checkOutput($sformatf("reset%0d.flags", d), {29'd0, rspO[d], errO[d], busyO[d]}, 32'd0);
    end
    @(negedge i_clk);
    i_rst = 1'b0;

    $display("[TB] directed accesses, no wait states");
    doTxn("w10", 0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
    doTxn("r10", 0, 1'b0, 4'b1111, 32'h10, 32'h0);
    checkOutput("r10.const", lastRd, 32'hDEADBEEF);
    doTxn("wb13", 0, 1'b1, 4'b0001, 32'h13, 32'h000000A5);
    doTxn("r10b", 0, 1'b0, 4'b1111, 32'h10, 32'h0);
    checkOutput("r10b.const", lastRd, 32'hA5ADBEEF);
    doTxn("rb11", 0, 1'b0, 4'b0001, 32'h11, 32'h0);
    checkOutput("rb11.const", lastRd, 32'h000000BE);
    doTxn("rh12", 0, 1'b0, 4'b0011, 32'h12, 32'h0);
    checkOutput("rh12.const", lastRd, 32'h0000A5AD);
    doTxn("wmis", 0, 1'b1, 4'b1111, 32'h12, 32'hFFFFFFFF);
    checkOutput("wmis.const", 32'(lastErr), 32'd1);
    doTxn("r10c", 0, 1'b0, 4'b1111, 32'h10, 32'h0);
    checkOutput("r10c.const", lastRd, 32'hA5ADBEEF);
    doTxn("roor", 0, 1'b0, 4'b1111, 32'd4096, 32'h0);
    checkOutput("roor.const", {lastRd[30:0], lastErr}, 32'd1);
    doTxn("bsel", 0, 1'b0, 4'b0111, 32'h10, 32'h0);
    checkOutput("bsel.const", 32'(lastErr), 32'd1);

    $display("[TB] three wait states, offset base, back-to-back reads");
    doTxn("d1under", 1, 1'b0, 4'b1111, BASE1 - 32'd4, 32'h0);
    doTxn("d1w8", 1, 1'b1, 4'b1111, BASE1 + 32'd8, 32'hCAFEF00D);
    modelTxn(1, 1'b0, 4'b1111, BASE1 + 32'd8, 32'h0, erd, eer);
    np = 0;
    pulseAt = '{-1, -1, -1};
    pRd = '{32'd0, 32'd0, 32'd0};
    @(negedge i_clk);
    we = 1'b0; sel = 4'b1111; addr = BASE1 + 32'd8; wdata = 32'd0;
    req[1] = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      @(posedge i_clk);
      #1;
      if (rspO[1]) begin
        if (np < 3) begin
          pulseAt[np] = t;
          pRd[np] = rdataO[1];
        end
        np++;
      end
    end
    req[1] = 1'b0;
    checkOutput("b2b.count", 32'(np), 32'd3);
    checkOutput("b2b.first", 32'(pulseAt[0]), 32'd4);
    checkOutput("b2b.second", 32'(pulseAt[1]), 32'd9);
    checkOutput("b2b.third", 32'(pulseAt[2]), 32'd14);
    for (int k = 0; k < 3; k++) checkOutput($sformatf("b2b.rd%0d", k), pRd[k], erd);
    @(posedge i_clk);
    #1;
    checkOutput("b2b.idle", 32'(busyO[1]), 32'd0);

    $display("[TB] random traffic");
    randomPhase(0, 40);
    randomPhase(1, 15);

    $display("[TB] reset during wait states");
    doTxn("d2old", 2, 1'b1, 4'b1111, 32'h20, 32'h12345678);
    @(negedge i_clk);
    we = 1'b1; sel = 4'b1111; addr = 32'h20; wdata = 32'h55AA55AA;
    req[2] = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("rst.busyWait", 32'(busyO[2]), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("rst.rsp", 32'(rspO[2]), 32'd0);
    checkOutput("rst.busy", 32'(busyO[2]), 32'd0);
    i_rst = 1'b0;
    req[2] = 1'b0;
    rspCount = 0;
    repeat (6) begin
      @(posedge i_clk);
      #1;
      if (rspO[2]) rspCount++;
    end
    checkOutput("rst.noRsp", 32'(rspCount), 32'd0);
    doTxn("d2r20", 2, 1'b0, 4'b1111, 32'h20, 32'h0);
    checkOutput("d2r20.const", lastRd, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
